// File: rtl/serial_operand_loader.sv
// serial_operand_loader
// Assembles two WIDTH-bit operands received MSB-first on one serial line
// (A first, then B) into shadow registers. The A/B output pair changes in a
// single edge, so the downstream stage only ever sees a complete old pair or
// a complete new pair.
//
// Handshake: a bit is taken on a rising edge when ser_valid=1 and the block is
// in LOAD_A or LOAD_B, and start=1 is not asserted on that edge. There is no
// back-pressure. op_valid is a one-cycle pulse on the edge that loads A/B.
// start always wins: it begins a new frame and discards any partial frame,
// including one whose final bit arrives on the same edge.

module serial_operand_loader #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             op_valid,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_A = 2'd1;
    localparam logic [1:0] LOAD_B = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shadow_a;
    logic [WIDTH-1:0] shadow_b;

    // A frame is in progress whenever the FSM is away from IDLE.
    assign busy = (state != IDLE);

    // Frame FSM, shadow shifting and atomic output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shadow_a <= '0;
            shadow_b <= '0;
            A        <= '0;
            B        <= '0;
            op_valid <= 1'b0;
        end else begin
            op_valid <= 1'b0;
            if (start) begin
                // New frame or restart: drop anything partially received.
                state    <= LOAD_A;
                bit_cnt  <= '0;
                shadow_a <= '0;
                shadow_b <= '0;
            end else begin
                case (state)
                    LOAD_A: begin
                        if (ser_valid) begin
                            shadow_a <= {shadow_a[WIDTH-2:0], ser_in};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= LOAD_B;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    LOAD_B: begin
                        if (ser_valid) begin
                            shadow_b <= {shadow_b[WIDTH-2:0], ser_in};
                            if (bit_cnt == LAST_BIT) begin
                                // Final bit goes straight to B so the pair
                                // appears on this same edge.
                                bit_cnt  <= '0;
                                state    <= IDLE;
                                A        <= shadow_a;
                                B        <= {shadow_b[WIDTH-2:0], ser_in};
                                op_valid <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        // IDLE: serial data is ignored until start.
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
